// File: rtl/ram_responder.sv
// Word-addressed RAM device for the mobo's RAM request/acknowledge handshake.
// It samples a request in IDLE, waits WAIT cycles, performs the access, and holds ack until the request is withdrawn.
module ram_responder #(
  parameter int ADDR_W        = 11,
  parameter int WAIT          = 2,
  parameter int RAM_WRITE_PIN = 0,
  parameter int RAM_READ_PIN  = 1,
  parameter int RAM_ACK       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_ctrl,
  output logic [31:0] ram_stat,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [7:0] WAIT_CNT = 8'(WAIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_e;

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic                op_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         data_q;
  logic [31:0]         rd_data_q;
  logic                ack_q;

  // NOTE: the storage array has no reset; contents survive rst and only the control path is cleared.
  logic [31:0]         mem [0:DEPTH-1];

  logic                wr_pin;
  logic                rd_pin;
  logic                access;
  logic                mem_we;
  logic                unused_bits;

  always_comb begin
    wr_pin = ram_ctrl[RAM_WRITE_PIN];
    rd_pin = ram_ctrl[RAM_READ_PIN];
    access = (state_q == BUSY) && (cnt_q == 8'd0);
    mem_we = access && op_wr_q && !rst;
  end

  // Upper address bits alias (wrap) and the remaining control pins are don't-care.
  assign unused_bits = ^{ram_ctrl, addr};

  // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Write wins when both pins are high.
          if (wr_pin || rd_pin) begin
            op_wr_q <= wr_pin;
            addr_q  <= addr[ADDR_W-1:0];
            data_q  <= wr_data;
            cnt_q   <= WAIT_CNT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            if (!op_wr_q) begin
              rd_data_q <= mem[addr_q];
            end
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          // Stay acknowledged until the requester drops both pins.
          if (!wr_pin && !rd_pin) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

  always_comb begin
    ram_stat          = '0;
    ram_stat[RAM_ACK] = ack_q;
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: instance 0 uses WAIT=2, instances 1 and 2 use WAIT=0 and WAIT=4.
module tb_ram_responder;

  localparam int WP      = 0;
  localparam int RP      = 1;
  localparam int ACK_BIT = 0;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl  [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] stat  [3];
  logic [31:0] rdata [3];

  int checks;
  int failures;

  ram_responder #(.ADDR_W(11), .WAIT(2), .RAM_WRITE_PIN(WP), .RAM_READ_PIN(RP), .RAM_ACK(ACK_BIT)) u_w2 (
    .clk(clk), .rst(rst), .ram_ctrl(ctrl[0]), .ram_stat(stat[0]),
    .addr(addr[0]), .wr_data(wdata[0]), .rd_data(rdata[0]));
  ram_responder #(.ADDR_W(11), .WAIT(0), .RAM_WRITE_PIN(WP), .RAM_READ_PIN(RP), .RAM_ACK(ACK_BIT)) u_w0 (
    .clk(clk), .rst(rst), .ram_ctrl(ctrl[1]), .ram_stat(stat[1]),
    .addr(addr[1]), .wr_data(wdata[1]), .rd_data(rdata[1]));
  ram_responder #(.ADDR_W(11), .WAIT(4), .RAM_WRITE_PIN(WP), .RAM_READ_PIN(RP), .RAM_ACK(ACK_BIT)) u_w4 (
    .clk(clk), .rst(rst), .ram_ctrl(ctrl[2]), .ram_stat(stat[2]),
    .addr(addr[2]), .wr_data(wdata[2]), .rd_data(rdata[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    case (d)
      0:       wait_of = 2;
      1:       wait_of = 0;
      default: wait_of = 4;
    endcase
  endfunction

  function automatic logic [31:0] pins(input bit wr, input bit rd);
    logic [31:0] p;
    p     = '0;
    p[WP] = wr;
    p[RP] = rd;
    return p;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full four-phase transaction; inputs change only on falling edges.
  task automatic txn(input int d, input bit wr, input bit rd, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, input bit withdraw,
                     input bit disturb, output logic [31:0] rdv);
    int lat;
    @(negedge clk);
    ctrl[d]  = pins(wr, rd);
    addr[d]  = a;
    wdata[d] = wd;
    @(negedge clk);
    if (withdraw) ctrl[d] = '0;
    if (disturb) begin
      addr[d]  = a ^ 32'h1;
      wdata[d] = ~wd;
    end
    lat = 0;
    while (stat[d][ACK_BIT] !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check32("ack_latency", 32'(lat), 32'(wait_of(d) + 1));
    rdv = rdata[d];
    for (int i = 0; i < hold; i++) begin
      wdata[d] = ~wd;
      @(negedge clk);
      check32("ack_held", stat[d], 32'h1);
      check32("rd_data_stable", rdata[d], rdv);
    end
    ctrl[d] = '0;
    @(negedge clk);
    check32("ack_fall", stat[d], 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ctrl[d]  = '0;
      addr[d]  = '0;
      wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check32("idle_stat", stat[0], 32'h0);
      check32("idle_rd_data", rdata[0], 32'h0);
    end

    txn(0, 1, 0, 32'd9, 32'h0, 0, 0, 0, v);
    check32("rd_unchanged_by_write", v, 32'h0);

    txn(0, 1, 0, 32'd5, 32'hDEADBEEF, 0, 0, 0, v);
    txn(0, 0, 1, 32'd5, 32'h0, 0, 0, 0, v);
    check32("read_addr5", v, 32'hDEADBEEF);

    txn(0, 1, 0, 32'd2055, 32'h11, 0, 0, 0, v);
    txn(0, 0, 1, 32'd7, 32'h0, 0, 0, 0, v);
    check32("wrap_read", v, 32'h11);

    txn(0, 1, 1, 32'd3, 32'h55, 0, 0, 0, v);
    check32("both_pins_rd_unchanged", v, 32'h11);
    txn(0, 0, 1, 32'd3, 32'h0, 0, 0, 0, v);
    check32("both_pins_write_done", v, 32'h55);

    txn(0, 1, 0, 32'd21, 32'hC, 0, 0, 0, v);
    txn(0, 1, 0, 32'd20, 32'hA0A0, 0, 0, 1, v);
    txn(0, 0, 1, 32'd20, 32'h0, 0, 0, 0, v);
    check32("busy_bus_change_addr20", v, 32'hA0A0);
    txn(0, 0, 1, 32'd21, 32'h0, 0, 0, 0, v);
    check32("busy_bus_change_addr21", v, 32'hC);

    txn(0, 1, 0, 32'd30, 32'h1234, 6, 0, 0, v);
    txn(0, 0, 1, 32'd30, 32'h0, 6, 0, 0, v);
    check32("hold_no_reexec", v, 32'h1234);

    txn(0, 1, 0, 32'd40, 32'h77, 0, 1, 0, v);
    txn(0, 0, 1, 32'd40, 32'h0, 0, 0, 0, v);
    check32("withdrawn_write_committed", v, 32'h77);

    // Reset lands while the write to addr 9 still has wait states left.
    @(negedge clk);
    ctrl[0]  = pins(1, 0);
    addr[0]  = 32'd9;
    wdata[0] = 32'hABCD;
    @(negedge clk);
    rst     = 1'b1;
    ctrl[0] = '0;
    @(negedge clk);
    check32("rst_ack", stat[0], 32'h0);
    check32("rst_rd_data", rdata[0], 32'h0);
    rst = 1'b0;
    txn(0, 0, 1, 32'd9, 32'h0, 0, 0, 0, v);
    check32("rst_write_abandoned", v, 32'h0);

    for (int d = 1; d < 3; d++) begin
      for (int idx = 0; idx < 2000; idx++) begin
        txn(d, 1, 0, 32'(idx), 32'(idx), 0, 0, 0, v);
        txn(d, 0, 1, 32'(idx), 32'h0, 0, 0, 0, v);
        check32(d == 1 ? "loop_w0_read" : "loop_w4_read", v, 32'(idx));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Synchronous word-addressed RAM device that answers the mobo's RAM request/acknowledge handshake. Sits on the device side of the `ram_ctrl` / `ram_stat` pair and the shared `addr` / data buses. It samples read or write requests, inserts a configurable number of wait states, performs the access, and holds `RAM_ACK` until the requester withdraws its request (four-phase handshake).

## Interface
- `ADDR_W`, 11: word-address width; depth = 2**ADDR_W 32-bit words.
- `WAIT`, 2: wait states between request sample and memory access (0..255).
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `ram_ctrl`  in  32: request pins; bits `RAM_WRITE_PIN` and `RAM_READ_PIN` (control_pins.v) are used, all others ignored.
- `ram_stat`  out  32: status; bit `RAM_ACK` = acknowledge, all other bits 0.
- `addr`  in  32: word address; only `addr[ADDR_W-1:0]` is used.
- `wr_data`  in  32: write data (driven by the mobo's `data_out`).
- `rd_data`  out  32: read data (feeds the mobo's `data_in`).

## Operation
- States: IDLE, BUSY, ACK. All outputs registered.
- IDLE: the write pin, read pin, `addr` and `wr_data` are sampled at each edge.
  - Write pin = 1: latch op = write, address, data; load `cnt <= WAIT`; go BUSY.
  - Only read pin = 1: latch op = read and address; load `cnt`; go BUSY.
  - Both pins = 1: write has priority; the read is not performed.
  - Neither pin = 1: stay IDLE.
- BUSY, `cnt != 0`: `cnt <= cnt - 1`.
- BUSY, `cnt == 0`: perform the access.
  - Write: `mem[a] <= data`.
  - Read: `rd_data <= mem[a]`.
  - Then `ack <= 1` and go ACK.
- ACK: `ack` is held at 1 and `rd_data` is held stable.
  - When both request pins are sampled 0: `ack <= 0`, go IDLE.
  - While either pin stays 1, remain in ACK. A request is never re-executed without an intervening ack-low cycle.
- Bus inputs are used only at the IDLE sampling edge. Later changes on `addr` or `wr_data` do not affect the access in flight.
- Address wrap: `addr` >= 2**ADDR_W aliases modulo 2**ADDR_W. Upper bits are ignored and no error is raised.
- A request withdrawn during BUSY is still committed. ACK then rises and falls on the following edge, because the pins are already low.
- `rd_data` keeps its last read value across writes. It changes only on a read access or on reset.

## Timing
- Reset values:
  - `ram_stat` = 0 (ack = 0).
  - `rd_data` = 0.
  - State = IDLE, `cnt` = 0.
- Memory contents are not cleared by reset.
- Reset mid-operation abandons the transaction. A write still in BUSY with `cnt != 0` is not committed.
- Latency, request sampled at edge 0:
  - The access occurs and `ack` rises at edge WAIT+1.
  - With WAIT=0, `ack` is high one cycle after the sample.
- `rd_data` becomes valid at the same edge `ack` rises and is stable for the whole ack-high interval.
- Release: the pins are sampled low at edge n, so `ack` = 0 after edge n. The earliest next request sample is at edge n+1.
- Throughput: at most one access per WAIT+3 cycles (sample, WAIT+1 busy edges, release).
- Request pins are combinational in the requester. Only their values at rising edges are meaningful; glitches between edges are ignored.

## Test plan
- Reset then idle with pins 0:
  - `ram_stat` = 0 and `rd_data` = 0 for 10 cycles.
  - No memory writes occur.
- WAIT=2. Write pin high, addr=5, wr_data=32'hDEADBEEF:
  - `ack` rises exactly 3 edges after the sample.
  - Drop the pin: `ack` is 0 after the next edge.
  - Then read addr=5: `rd_data` = 32'hDEADBEEF when `ack` rises.
- Wrap: write 32'h11 to addr=2048+7 (ADDR_W=11), then read addr=7 -> `rd_data` = 32'h11.
- Both pins high, addr=3, wr_data=32'h55:
  - The write is performed.
  - `rd_data` is unchanged from its prior value.
  - A later read of addr 3 returns 32'h55.
- Mid-operation cases:
  - Change `addr` and `wr_data` during BUSY: the originally sampled address and data are used.
  - Hold the request pin high for 6 cycles after ack: `ack` stays 1 and there is no second access.
  - Assert `rst` during BUSY of a write to addr=9 (old value 32'h0): `ack` = 0 next edge and `mem[9]` stays 32'h0.
- Mobo-style loop, WAIT=0 and WAIT=4:
  - Sequence per index: write idx, read idx, for idx = 0..1999.
  - Every read returns idx.
  - Each transaction completes with a clean ack rise and fall.
